// File: rtl/pll_phase_pkg.sv
// pll_phase_pkg: shared definitions for the PLL dynamic-phase-shift arbiter.
//   - PLL counter-select codes driven on phasecounterselect
//   - sequencer state encoding
//   - default timing parameters
package pll_phase_pkg;

    localparam logic [2:0] SEL_ALL = 3'b000;
    localparam logic [2:0] SEL_M   = 3'b001;
    localparam logic [2:0] SEL_C0  = 3'b010;
    localparam logic [2:0] SEL_C1  = 3'b011;
    localparam logic [2:0] SEL_C2  = 3'b100;
    localparam logic [2:0] SEL_C3  = 3'b101;
    localparam logic [2:0] SEL_C4  = 3'b110;

    localparam int DEF_SCAN_DIV  = 16;
    localparam int DEF_STEP_HOLD = 2;
    localparam int DEF_TIMEOUT   = 100;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STEP   = 3'd2,
        ST_WAITLO = 3'd3,
        ST_WAITHI = 3'd4,
        ST_NEXT   = 3'd5,
        ST_FIN    = 3'd6
    } state_t;

endpackage

// File: rtl/pll_phase_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   i_req   : request vector
//   i_ptr   : index of the last-served requester; search starts at i_ptr+1
//   i_en    : pick only when high
//   o_grant : one-hot winner
//   o_idx   : winner index
//   o_valid : a winner exists
module rr_arbiter
    import pll_phase_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]         i_req,
    input  logic [$clog2(N_REQ)-1:0] i_ptr,
    input  logic                     i_en,
    output logic [N_REQ-1:0]         o_grant,
    output logic [$clog2(N_REQ)-1:0] o_idx,
    output logic                     o_valid
);

    always_comb begin
        int w_cand;
        w_cand  = 0;
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        if (i_en) begin
            // off == N_REQ lands back on the pointer itself, so it is checked last
            for (int off = 1; off <= N_REQ; off++) begin
                w_cand = (int'(i_ptr) + off) % N_REQ;
                if (!o_valid && i_req[w_cand]) begin
                    o_valid         = 1'b1;
                    o_idx           = $clog2(N_REQ)'(w_cand);
                    o_grant[w_cand] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pll_phase_arbiter.sv
// pll_phase_arbiter: shares one PLL dynamic-phase-shift port between N_REQ
// requesters. Grants round-robin, generates scanclk, pulses phasestep once per
// step and waits for the phase_done low->high handshake after each step.
//   i_clk, i_reset_n        : system clock, synchronous active-low reset
//   i_req/i_sel_in/i_updown_in/i_nsteps_in : per-requester request and parameters
//   o_grant, o_done, o_err, o_busy         : service status back to requesters
//   i_phase_done, o_scanclk, o_phasestep,
//   o_phasecounterselect, o_phaseupdown    : PLL reconfiguration pins
module pll_phase_arbiter
    import pll_phase_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int SCAN_DIV  = DEF_SCAN_DIV,
    parameter int STEP_HOLD = DEF_STEP_HOLD,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [3*N_REQ-1:0]   i_sel_in,
    input  logic [N_REQ-1:0]     i_updown_in,
    input  logic [8*N_REQ-1:0]   i_nsteps_in,
    output logic [N_REQ-1:0]     o_grant,
    output logic [N_REQ-1:0]     o_done,
    output logic                 o_err,
    output logic                 o_busy,
    input  logic                 i_phase_done,
    output logic                 o_scanclk,
    output logic                 o_phasestep,
    output logic [2:0]           o_phasecounterselect,
    output logic                 o_phaseupdown
);

    localparam int IW = $clog2(N_REQ);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int RW = $clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [RW-1:0] HOLD_N   = RW'(STEP_HOLD);
    localparam logic [RW-1:0] TO_N     = RW'(TIMEOUT);

    state_t          r_state;
    logic [IW-1:0]   r_ptr;
    logic [2:0]      r_sel;
    logic            r_ud;
    logic [7:0]      r_nsteps;
    logic [7:0]      r_stepcnt;
    logic [DW-1:0]   r_div;
    logic [RW-1:0]   r_rise;
    logic            r_errflag;
    logic [N_REQ-1:0] r_grant;
    logic [N_REQ-1:0] r_done;
    logic            r_err;
    logic            r_busy;
    logic            r_scanclk;
    logic            r_phasestep;
    logic [2:0]      r_pcs;
    logic            r_pud;

    logic [N_REQ-1:0] w_arb_grant;
    logic [IW-1:0]    w_arb_idx;
    logic             w_arb_valid;
    logic             w_clocking;
    logic             w_div_wrap;
    logic             w_rise;
    logic [RW-1:0]    w_rise_cnt;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .i_en    (r_state == ST_IDLE),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    // scanclk runs only while a step is in flight; it is frozen for the single
    // NEXT cycle so every rise lands in a state that counts it.
    assign w_clocking = (r_state == ST_STEP) || (r_state == ST_WAITLO) ||
                        (r_state == ST_WAITHI);
    assign w_div_wrap = (r_div == DIV_LAST);
    assign w_rise     = w_clocking && w_div_wrap && !r_scanclk;
    assign w_rise_cnt = r_rise + RW'(1);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_sel       <= SEL_ALL;
            r_ud        <= 1'b1;
            r_nsteps    <= '0;
            r_stepcnt   <= '0;
            r_div       <= '0;
            r_rise      <= '0;
            r_errflag   <= 1'b0;
            r_grant     <= '0;
            r_done      <= '0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_scanclk   <= 1'b0;
            r_phasestep <= 1'b0;
            r_pcs       <= SEL_ALL;
            r_pud       <= 1'b1;
        end else begin
            r_done <= '0;
            r_err  <= 1'b0;
            if (w_clocking) begin
                if (w_div_wrap) begin
                    r_div     <= '0;
                    r_scanclk <= ~r_scanclk;
                end else begin
                    r_div <= r_div + DW'(1);
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_valid) begin
                        r_grant   <= w_arb_grant;
                        r_ptr     <= w_arb_idx;
                        r_busy    <= 1'b1;
                        r_sel     <= i_sel_in[int'(w_arb_idx)*3 +: 3];
                        r_ud      <= i_updown_in[w_arb_idx];
                        r_nsteps  <= i_nsteps_in[int'(w_arb_idx)*8 +: 8];
                        r_stepcnt <= '0;
                        r_errflag <= 1'b0;
                        r_state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_pcs  <= r_sel;
                    r_pud  <= r_ud;
                    r_div  <= '0;
                    r_rise <= '0;
                    if (r_nsteps == 8'd0) begin
                        r_state <= ST_FIN;
                    end else begin
                        r_phasestep <= 1'b1;
                        r_state     <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    if (w_rise) begin
                        if (w_rise_cnt == HOLD_N) begin
                            r_phasestep <= 1'b0;
                            r_rise      <= '0;   // timeout window starts here
                            r_state     <= ST_WAITLO;
                        end else begin
                            r_rise <= w_rise_cnt;
                        end
                    end
                end
                // Timeout is tested before phase_done so the counter can never
                // run past TIMEOUT and miss the abort.
                ST_WAITLO: begin
                    if (w_rise) begin
                        r_rise <= w_rise_cnt;
                        if (w_rise_cnt == TO_N) begin
                            r_errflag <= 1'b1;
                            r_state   <= ST_FIN;
                        end else if (!i_phase_done) begin
                            r_state <= ST_WAITHI;
                        end
                    end
                end
                ST_WAITHI: begin
                    if (w_rise) begin
                        r_rise <= w_rise_cnt;
                        if (w_rise_cnt == TO_N) begin
                            r_errflag <= 1'b1;
                            r_state   <= ST_FIN;
                        end else if (i_phase_done) begin
                            r_stepcnt <= r_stepcnt + 8'd1;
                            r_state   <= ST_NEXT;
                        end
                    end
                end
                ST_NEXT: begin
                    if (r_stepcnt == r_nsteps) begin
                        r_state <= ST_FIN;
                    end else begin
                        r_phasestep <= 1'b1;
                        r_rise      <= '0;
                        r_state     <= ST_STEP;
                    end
                end
                ST_FIN: begin
                    r_scanclk   <= 1'b0;
                    r_phasestep <= 1'b0;
                    r_div       <= '0;
                    r_done      <= r_grant;
                    r_err       <= r_errflag;
                    r_grant     <= '0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_grant              = r_grant;
    assign o_done               = r_done;
    assign o_err                = r_err;
    assign o_busy               = r_busy;
    assign o_scanclk            = r_scanclk;
    assign o_phasestep          = r_phasestep;
    assign o_phasecounterselect = r_pcs;
    assign o_phaseupdown        = r_pud;

endmodule

// File: tb/tb_pll_phase_arbiter.sv
// Directed bench for pll_phase_arbiter with a small PLL phase_done model.
module tb_pll_phase_arbiter;
    import pll_phase_pkg::*;

    localparam int N         = 2;
    localparam int STEP_HOLD = 2;
    localparam int TIMEOUT   = 100;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [3*N-1:0] sel_in = '0;
    logic [N-1:0]   ud_in = '1;
    logic [8*N-1:0] ns_in = '0;
    logic           pd;
    logic [N-1:0]   o_grant, o_done;
    logic           o_err, o_busy, o_scanclk, o_phasestep, o_phaseupdown;
    logic [2:0]     o_phasecounterselect;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    pll_phase_arbiter #(
        .N_REQ(N), .SCAN_DIV(16), .STEP_HOLD(STEP_HOLD), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_req(req), .i_sel_in(sel_in),
        .i_updown_in(ud_in), .i_nsteps_in(ns_in), .o_grant(o_grant),
        .o_done(o_done), .o_err(o_err), .o_busy(o_busy), .i_phase_done(pd),
        .o_scanclk(o_scanclk), .o_phasestep(o_phasestep),
        .o_phasecounterselect(o_phasecounterselect), .o_phaseupdown(o_phaseupdown)
    );

    // ---- monitor + PLL model (negedge, cumulative counters) ----
    int   n_rise = 0, n_pulse = 0, n_badw = 0, n_done = 0, n_ovl = 0, n_selv = 0;
    int   rsf = 0, width = 0, svc_r = 0, pm_cnt = 0;
    logic prev_sc = 1'b0, prev_ps = 1'b0, prev_pud = 1'b1, pm_arm = 1'b0;
    logic pll_hold = 1'b0;
    logic [2:0]   prev_pcs = '0;
    logic [N-1:0] prev_grant = '0;
    logic sc_rise, ps_fall;
    assign sc_rise = o_scanclk && !prev_sc;
    assign ps_fall = !o_phasestep && prev_ps;

    always @(negedge clk) begin
        prev_sc    <= o_scanclk;
        prev_ps    <= o_phasestep;
        prev_pcs   <= o_phasecounterselect;
        prev_pud   <= o_phaseupdown;
        prev_grant <= o_grant;
        if (sc_rise) n_rise <= n_rise + 1;
        if (o_done != '0) n_done <= n_done + 1;
        if ($countones(o_grant) > 1) n_ovl <= n_ovl + 1;
        if (o_phasestep && !prev_ps) begin
            n_pulse <= n_pulse + 1;
            width   <= 0;
        end else if (ps_fall) begin
            if (width + (sc_rise ? 1 : 0) != STEP_HOLD) n_badw <= n_badw + 1;
            width <= 0;
        end else if (o_phasestep && sc_rise) begin
            width <= width + 1;
        end
        if (ps_fall) rsf <= 0;
        else if (sc_rise) rsf <= rsf + 1;
        if (o_grant != prev_grant) svc_r <= 0;
        else if (sc_rise) svc_r <= svc_r + 1;
        if (o_grant != '0 && o_grant == prev_grant && svc_r != 0 &&
            (o_phasecounterselect != prev_pcs || o_phaseupdown != prev_pud))
            n_selv <= n_selv + 1;
        // PLL: phase_done drops 2 scanclk rises after phasestep falls, back up 2 later
        if (!reset_n) begin
            pd     <= 1'b1;
            pm_arm <= 1'b0;
            pm_cnt <= 0;
        end else if (ps_fall) begin
            pm_arm <= 1'b1;
            pm_cnt <= 0;
        end else if (pm_arm && sc_rise) begin
            pm_cnt <= pm_cnt + 1;
            if (pm_cnt + 1 == 2 && !pll_hold) pd <= 1'b0;
            if (pm_cnt + 1 == 4) begin
                pd     <= 1'b1;
                pm_arm <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #5;
    endtask

    task automatic wait_grant(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (o_grant != '0) ok = 1'b1;
            else tick();
        end
        chk(tag, 32'(ok), 1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (o_done != '0) ok = 1'b1;
            else tick();
        end
        chk(tag, 32'(ok), 1);
    endtask

    int  p0, r0, d0, gc;
    logic ok;

    initial begin
        // ---- reset state ----
        reset_n = 1'b0;
        repeat (2) tick();
        chk("rst_grant", 32'(o_grant), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_err", 32'(o_err), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_scanclk", 32'(o_scanclk), 0);
        chk("rst_phasestep", 32'(o_phasestep), 0);
        chk("rst_pcs", 32'(o_phasecounterselect), 0);
        chk("rst_pud", 32'(o_phaseupdown), 1);

        // ---- T1: single request, 3 steps ----
        sel_in[2:0] = SEL_ALL; ud_in[0] = 1'b1; ns_in[7:0] = 8'd3;
        reset_n = 1'b1;
        p0 = n_pulse;
        req = 2'b01;
        wait_grant("t1_grant_seen");
        chk("t1_grant", 32'(o_grant), 1);
        chk("t1_busy_on", 32'(o_busy), 1);
        req = '0;
        wait_done("t1_done_seen", 4000);
        chk("t1_done", 32'(o_done), 1);
        chk("t1_err", 32'(o_err), 0);
        chk("t1_busy", 32'(o_busy), 0);
        chk("t1_scanclk", 32'(o_scanclk), 0);
        chk("t1_grant_rel", 32'(o_grant), 0);
        chk("t1_pulses", 32'(n_pulse - p0), 3);
        chk("t1_pud", 32'(o_phaseupdown), 1);
        tick();
        chk("t1_done_1cyc", 32'(o_done), 0);

        // ---- T2: contention from reset, req=11 ----
        reset_n = 1'b0;
        repeat (2) tick();
        sel_in = {SEL_M, SEL_C0}; ud_in = 2'b10; ns_in = {8'd1, 8'd2}; req = 2'b11;
        reset_n = 1'b1;
        p0 = n_pulse;
        wait_grant("t2a_grant_seen");
        chk("t2a_grant", 32'(o_grant), 2);
        req = 2'b01;
        wait_done("t2a_done_seen", 4000);
        chk("t2a_done", 32'(o_done), 2);
        chk("t2a_err", 32'(o_err), 0);
        chk("t2a_pulses", 32'(n_pulse - p0), 1);
        chk("t2a_pcs", 32'(o_phasecounterselect), 32'(SEL_M));
        chk("t2a_pud", 32'(o_phaseupdown), 1);
        p0 = n_pulse;
        tick();
        wait_grant("t2b_grant_seen");
        chk("t2b_grant", 32'(o_grant), 1);
        req = '0;
        wait_done("t2b_done_seen", 4000);
        chk("t2b_done", 32'(o_done), 1);
        chk("t2b_pulses", 32'(n_pulse - p0), 2);
        chk("t2b_pcs", 32'(o_phasecounterselect), 32'(SEL_C0));
        chk("t2b_pud", 32'(o_phaseupdown), 0);

        // ---- T3: nsteps = 0 ----
        reset_n = 1'b0;
        repeat (2) tick();
        ns_in = '0; req = 2'b10;
        reset_n = 1'b1;
        r0 = n_rise;
        wait_grant("t3_grant_seen");
        req = '0;
        gc = 0;
        while (o_grant != '0 && gc < 10) begin
            gc++;
            tick();
        end
        chk("t3_grant_cycles", 32'(gc), 2);
        chk("t3_done", 32'(o_done), 2);
        chk("t3_err", 32'(o_err), 0);
        chk("t3_rises", 32'(n_rise - r0), 0);

        // ---- T4: timeout, phase_done stuck high ----
        reset_n = 1'b0;
        repeat (2) tick();
        pll_hold = 1'b1;
        ns_in = {8'd0, 8'd5}; ud_in = 2'b11; req = 2'b01;
        reset_n = 1'b1;
        p0 = n_pulse;
        wait_grant("t4_grant_seen");
        req = '0;
        wait_done("t4_done_seen", 6000);
        chk("t4_done", 32'(o_done), 1);
        chk("t4_err", 32'(o_err), 1);
        chk("t4_pulses", 32'(n_pulse - p0), 1);
        chk("t4_rises_waitlo", 32'(rsf), TIMEOUT);
        pll_hold = 1'b0;
        tick();
        chk("t4_err_1cyc", 32'(o_err), 0);

        // ---- T5: reset during WAITHI of step 2 ----
        reset_n = 1'b0;
        repeat (2) tick();
        sel_in = {SEL_ALL, SEL_C1}; ud_in = 2'b11; ns_in = {8'd0, 8'd3}; req = 2'b01;
        reset_n = 1'b1;
        wait_grant("t5_grant_seen");
        p0 = n_pulse;
        d0 = n_done;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            if (n_pulse - p0 == 2 && pd == 1'b0) ok = 1'b1;
            else tick();
        end
        for (int i = 0; i < 100 && o_scanclk; i++) tick();
        for (int i = 0; i < 100 && !o_scanclk; i++) tick();
        chk("t5_reached_waithi", 32'(ok), 1);
        reset_n = 1'b0;
        tick();
        chk("t5_rst_grant", 32'(o_grant), 0);
        chk("t5_rst_done", 32'(o_done), 0);
        chk("t5_rst_busy", 32'(o_busy), 0);
        chk("t5_rst_phasestep", 32'(o_phasestep), 0);
        chk("t5_rst_scanclk", 32'(o_scanclk), 0);
        chk("t5_rst_pcs", 32'(o_phasecounterselect), 0);
        chk("t5_rst_pud", 32'(o_phaseupdown), 1);
        tick();
        chk("t5_no_done", 32'(n_done - d0), 0);
        reset_n = 1'b1;
        p0 = n_pulse;
        wait_grant("t5_regrant_seen");
        chk("t5_regrant", 32'(o_grant), 1);
        req = '0;
        wait_done("t5_done_seen", 4000);
        chk("t5_done", 32'(o_done), 1);
        chk("t5_pulses", 32'(n_pulse - p0), 3);

        // ---- T6: inputs changed mid-service ----
        reset_n = 1'b0;
        repeat (2) tick();
        sel_in = {SEL_ALL, SEL_C1}; ud_in = 2'b10; ns_in = {8'd0, 8'd4}; req = 2'b01;
        reset_n = 1'b1;
        wait_grant("t6_grant_seen");
        p0 = n_pulse;
        tick();
        ns_in = {8'd0, 8'd1}; ud_in = 2'b11; sel_in = {SEL_ALL, SEL_ALL}; req = '0;
        wait_done("t6_done_seen", 6000);
        chk("t6_done", 32'(o_done), 1);
        chk("t6_err", 32'(o_err), 0);
        chk("t6_pulses", 32'(n_pulse - p0), 4);
        chk("t6_pud", 32'(o_phaseupdown), 0);
        chk("t6_pcs", 32'(o_phasecounterselect), 32'(SEL_C1));

        // ---- global invariants ----
        tick();
        chk("grant_overlap", 32'(n_ovl), 0);
        chk("sel_change_mid_service", 32'(n_selv), 0);
        chk("phasestep_width", 32'(n_badw), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
